// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cpu_pkg
// Description : Shared enumerations for the CPU program-counter and
//               memory-access logic.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package cpu_pkg;

   // Memory bus command encoding
   typedef enum logic [1:0] {
      CMD_NONE  = 2'b00,
      CMD_READ  = 2'b01,
      CMD_WRITE = 2'b10
   } mem_cmd_t;

   // Next-PC source select
   typedef enum logic [1:0] {
      PC_INC = 2'd0,
      PC_REL = 2'd1,
      PC_ABS = 2'd2,
      PC_RST = 2'd3
   } pc_sel_t;

   // Memory access unit control states
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_LOAD  = 2'd2,
      S_STORE = 2'd3
   } mau_state_t;

endpackage
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : Program counter register with next-PC mux and adder.
//               Supports increment, PC-relative, absolute and reset targets,
//               plus a post-fetch increment.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module pc_unit
   import cpu_pkg::*;
#(
   parameter int ADDR_W   = 9,
   parameter int DATA_W   = 16,
   parameter int RESET_PC = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load_pc,
   input  logic [1:0]        pc_sel,
   input  logic [DATA_W-1:0] branch_off,
   input  logic [ADDR_W-1:0] abs_target,
   input  logic              inc,
   output logic [ADDR_W-1:0] pc
);

   localparam logic [ADDR_W-1:0] c_RESET_PC = ADDR_W'(RESET_PC);
   localparam logic [ADDR_W-1:0] c_ONE      = ADDR_W'(1);

   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_next;
   logic [ADDR_W-1:0] w_pc_inc;
   logic [ADDR_W-1:0] w_off;

   // The offset is sign-extended and then truncated to ADDR_W; only the low
   // ADDR_W bits ever matter because the sum wraps.
   generate
      if (DATA_W > ADDR_W) begin : g_off_trunc
         logic w_unused_off_hi;
         assign w_off           = branch_off[ADDR_W-1:0];
         assign w_unused_off_hi = ^branch_off[DATA_W-1:ADDR_W];
      end else if (DATA_W == ADDR_W) begin : g_off_same
         assign w_off = branch_off;
      end else begin : g_off_sext
         assign w_off = {{(ADDR_W-DATA_W){branch_off[DATA_W-1]}}, branch_off};
      end
   endgenerate

   assign w_pc_inc = r_pc + c_ONE;

   // Next-PC selection: an explicit load takes precedence over fetch increment
   always_comb begin
      w_pc_next = r_pc;
      if (load_pc) begin
         case (pc_sel)
            PC_INC:  w_pc_next = w_pc_inc;
            PC_REL:  w_pc_next = w_pc_inc + w_off;
            PC_ABS:  w_pc_next = abs_target;
            PC_RST:  w_pc_next = c_RESET_PC;
            default: w_pc_next = r_pc;
         endcase
      end else if (inc) begin
         w_pc_next = w_pc_inc;
      end
   end

   // PC register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_pc <= c_RESET_PC;
      else          r_pc <= w_pc_next;
   end

   assign pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : PC, data-address and instruction registers plus the control
//               FSM that runs fetch/load/store over a ready-handshake memory
//               bus with wait states and an optional stall timeout.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module mem_access_unit
   import cpu_pkg::*;
#(
   parameter int ADDR_W   = 9,
   parameter int DATA_W   = 16,
   parameter int RESET_PC = 0,
   parameter int MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              fetch_req,
   input  logic              load_req,
   input  logic              store_req,
   input  logic              load_addr,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] wdata,
   input  logic              load_pc,
   input  logic [1:0]        pc_sel,
   input  logic [DATA_W-1:0] branch_off,
   input  logic [ADDR_W-1:0] abs_target,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        mem_cmd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] ir,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int                c_WAIT_W     = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
   localparam bit                c_TIMEOUT_EN = (MAX_WAIT != 0);
   localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MAX_WAIT - 1);

   mau_state_t          r_state;
   mau_state_t          w_state_next;
   mem_cmd_t            w_cmd;
   logic [ADDR_W-1:0]   w_mem_addr;
   logic                w_complete;
   logic                w_timeout;
   logic                w_accept;
   logic [ADDR_W-1:0]   w_pc;

   logic [ADDR_W-1:0]   r_addr_reg;
   logic [ADDR_W-1:0]   r_acc_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [c_WAIT_W-1:0] r_wait;
   logic [DATA_W-1:0]   r_ir;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_done;
   logic                r_err;

   // PC loads are only honoured in IDLE; fetch completion bumps the PC
   pc_unit #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .RESET_PC (RESET_PC)
   ) u_pc_unit (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_pc    (load_pc && (r_state == S_IDLE)),
      .pc_sel     (pc_sel),
      .branch_off (branch_off),
      .abs_target (abs_target),
      .inc        (w_complete && (r_state == S_FETCH)),
      .pc         (w_pc)
   );

   // Next-state, bus command and completion/timeout decode
   always_comb begin
      w_state_next = r_state;
      w_cmd        = CMD_NONE;
      w_mem_addr   = w_pc;
      w_complete   = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         S_IDLE: begin
            // A concurrent load_pc suppresses the fetch; lower requests are
            // still dropped because fetch outranks them.
            if (fetch_req) begin
               if (!load_pc) w_state_next = S_FETCH;
            end else if (load_req) begin
               w_state_next = S_LOAD;
            end else if (store_req) begin
               w_state_next = S_STORE;
            end
         end
         S_FETCH: begin
            w_cmd      = CMD_READ;
            w_mem_addr = w_pc;
         end
         S_LOAD: begin
            w_cmd      = CMD_READ;
            w_mem_addr = r_acc_addr;
         end
         S_STORE: begin
            w_cmd      = CMD_WRITE;
            w_mem_addr = r_acc_addr;
         end
         default: w_state_next = S_IDLE;
      endcase
      if (r_state != S_IDLE) begin
         if (mem_ready) begin
            w_complete   = 1'b1;
            w_state_next = S_IDLE;
         end else if (c_TIMEOUT_EN && (r_wait == c_WAIT_LAST)) begin
            w_timeout    = 1'b1;
            w_state_next = S_IDLE;
         end
      end
   end

   assign w_accept = (r_state == S_IDLE) && (w_state_next != S_IDLE);

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_next;
   end

   // Address/data latches, wait counter, IR/rdata capture and status pulses
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_addr_reg <= '0;
         r_acc_addr <= '0;
         r_wdata    <= '0;
         r_wait     <= '0;
         r_ir       <= '0;
         r_rdata    <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         if (load_addr) r_addr_reg <= addr_in;
         if (w_accept) begin
            r_wait     <= '0;
            r_acc_addr <= r_addr_reg;
            if (w_state_next == S_STORE) r_wdata <= wdata;
         end else if ((r_state != S_IDLE) && !mem_ready) begin
            r_wait <= r_wait + c_WAIT_W'(1);
         end
         if (w_complete && (r_state == S_FETCH)) r_ir    <= mem_rdata;
         if (w_complete && (r_state == S_LOAD))  r_rdata <= mem_rdata;
         r_done <= w_complete;
         r_err  <= w_timeout;
      end
   end

   assign mem_cmd   = w_cmd;
   assign mem_addr  = w_mem_addr;
   assign mem_wdata = r_wdata;
   assign ir        = r_ir;
   assign rdata     = r_rdata;
   assign pc        = w_pc;
   assign busy      = (r_state != S_IDLE);
   assign done      = r_done;
   assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit (MAX_WAIT=4).
//               Expected register contents are queued when a request is
//               driven and compared when done/err appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        fetch_req = 1'b0, load_req = 1'b0, store_req = 1'b0;
   logic        load_addr = 1'b0;
   logic [8:0]  addr_in = '0;
   logic [15:0] wdata = '0;
   logic        load_pc = 1'b0;
   logic [1:0]  pc_sel = '0;
   logic [15:0] branch_off = '0;
   logic [8:0]  abs_target = '0;
   logic        mem_ready = 1'b0;
   logic [15:0] mem_rdata = '0;
   logic [1:0]  mem_cmd;
   logic [8:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] ir;
   logic [15:0] rdata;
   logic [8:0]  pc;
   logic        busy, done, err;

   always #5 clk = ~clk;

   mem_access_unit #(
      .ADDR_W(9), .DATA_W(16), .RESET_PC(0), .MAX_WAIT(4)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .fetch_req(fetch_req), .load_req(load_req), .store_req(store_req),
      .load_addr(load_addr), .addr_in(addr_in), .wdata(wdata),
      .load_pc(load_pc), .pc_sel(pc_sel), .branch_off(branch_off),
      .abs_target(abs_target), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .ir(ir), .rdata(rdata), .pc(pc), .busy(busy), .done(done), .err(err)
   );

   typedef struct {
      logic [15:0] ir;
      logic [15:0] rdata;
      logic [8:0]  pc;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] m_ir = '0;
   logic [15:0] m_rdata = '0;
   logic [8:0]  m_pc = '0;
   logic [8:0]  m_addr = '0;
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   // kind: 0=fetch 1=load 2=store. Called and returns positioned just after a negedge.
   task automatic access(input int kind, input int stalls, input logic [15:0] rd,
                         input logic [15:0] wd, input bit exp_err, input int exp_lat,
                         input logic [8:0] next_addr, input bit poke_pc);
      exp_t        e;
      int          n;
      int          cmd_cnt;
      bit          seen;
      logic [8:0]  a_exp;
      logic [1:0]  c_exp;
      a_exp = (kind == 0) ? m_pc : m_addr;
      c_exp = (kind == 2) ? 2'b10 : 2'b01;
      e.ir = m_ir; e.rdata = m_rdata; e.pc = m_pc;
      if (!exp_err) begin
         if (kind == 0) begin e.ir = rd; e.pc = m_pc + 9'd1; end
         else if (kind == 1) e.rdata = rd;
      end
      sb.push_back(e);
      fetch_req = (kind == 0); load_req = (kind == 1); store_req = (kind == 2);
      wdata = wd; mem_rdata = rd; mem_ready = 1'b0;
      @(posedge clk); #1;
      fetch_req = 1'b0; load_req = 1'b0; store_req = 1'b0;
      wdata = ~wd;
      n = 0; cmd_cnt = 0; seen = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (n == 2) begin load_addr = 1'b0; load_pc = 1'b0; end
         if (done || err) begin
            seen = 1'b1;
         end else begin
            if (mem_cmd == c_exp) cmd_cnt++;
            if (n == 1) begin
               check_eq("acc_addr", mem_addr, a_exp);
               check_eq("busy_acc", busy, 1'b1);
               if (kind == 2) check_eq("st_wdata", mem_wdata, wd);
               load_addr = 1'b1; addr_in = next_addr;
               if (poke_pc) begin load_pc = 1'b1; pc_sel = 2'd2; abs_target = 9'h0AA; end
            end
            if (n == 2 && kind != 0) check_eq("addr_hold", mem_addr, a_exp);
            mem_ready = (n > stalls);
         end
      end
      load_addr = 1'b0; load_pc = 1'b0; mem_ready = 1'b0;
      m_addr = next_addr;
      check_eq("latency", n, exp_lat);
      check_eq("cmd_cycles", cmd_cnt, exp_lat - 1);
      check_eq("done", done, !exp_err);
      check_eq("err", err, exp_err);
      check_eq("busy_end", busy, 1'b0);
      e = sb.pop_front();
      check_eq("ir", ir, e.ir);
      check_eq("rdata", rdata, e.rdata);
      check_eq("pc", pc, e.pc);
      m_ir = e.ir; m_rdata = e.rdata; m_pc = e.pc;
   endtask

   // Apply load_pc in IDLE and check the resulting PC against the model.
   task automatic pc_load(input logic [1:0] sel, input logic [15:0] off, input logic [8:0] tgt);
      case (sel)
         2'd0: m_pc = m_pc + 9'd1;
         2'd1: m_pc = m_pc + 9'd1 + off[8:0];
         2'd2: m_pc = tgt;
         default: m_pc = 9'd0;
      endcase
      load_pc = 1'b1; pc_sel = sel; branch_off = off; abs_target = tgt;
      @(posedge clk); #1;
      load_pc = 1'b0;
      @(negedge clk);
      check_eq("pc_load", pc, m_pc);
      check_eq("pc_load_busy", busy, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int done_seen;
      repeat (2) @(negedge clk);
      check_eq("rst_pc", pc, 9'h000);
      check_eq("rst_ir", ir, 16'h0);
      check_eq("rst_rdata", rdata, 16'h0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_cmd", mem_cmd, 2'b00);
      check_eq("rst_done_err", {done, err}, 2'b00);
      check_eq("rst_wdata", mem_wdata, 16'h0);
      reset_n = 1'b1;
      @(negedge clk);

      // zero-wait fetch, then one-cycle done pulse
      access(0, 0, 16'hD101, 16'h0, 1'b0, 2, 9'h010, 1'b0);
      @(negedge clk);
      check_eq("done_pulse", done, 1'b0);
      // load from 0x10 with 3 stalls
      access(1, 3, 16'hBEEF, 16'h0, 1'b0, 5, 9'h033, 1'b0);

      // PC target selection and wrap
      pc_load(2'd2, 16'h0000, 9'h005);
      pc_load(2'd1, 16'hFFFD, 9'h000);
      pc_load(2'd0, 16'h0000, 9'h000);
      pc_load(2'd1, 16'h0010, 9'h000);
      pc_load(2'd3, 16'h0000, 9'h000);
      pc_load(2'd2, 16'h0000, 9'h1FF);
      access(0, 1, 16'h1234, 16'h0, 1'b0, 3, 9'h044, 1'b1);

      // store timeout, then a normal store with a busy load_pc attempt
      access(2, 99, 16'h0, 16'h5A5A, 1'b1, 5, 9'h055, 1'b0);
      @(negedge clk);
      check_eq("err_pulse", err, 1'b0);
      access(2, 2, 16'h0, 16'hA5C3, 1'b0, 4, 9'h066, 1'b1);

      // back-to-back accesses
      access(0, 0, 16'h2222, 16'h0, 1'b0, 2, 9'h077, 1'b0);
      access(1, 0, 16'h3333, 16'h0, 1'b0, 2, 9'h088, 1'b0);

      // fetch together with load_pc: PC jumps, no access
      fetch_req = 1'b1; load_pc = 1'b1; pc_sel = 2'd2; abs_target = 9'h020;
      @(posedge clk); #1;
      fetch_req = 1'b0; load_pc = 1'b0;
      @(negedge clk);
      check_eq("fl_pc", pc, 9'h020);
      check_eq("fl_busy", busy, 1'b0);
      check_eq("fl_cmd", mem_cmd, 2'b00);
      @(negedge clk);
      check_eq("fl_busy2", busy, 1'b0);

      // async reset in the middle of a load
      load_req = 1'b1; mem_ready = 1'b0;
      @(posedge clk); #1;
      load_req = 1'b0;
      @(negedge clk);
      check_eq("mid_busy", busy, 1'b1);
      check_eq("mid_cmd", mem_cmd, 2'b01);
      #2 reset_n = 1'b0;
      #1;
      check_eq("ar_cmd", mem_cmd, 2'b00);
      check_eq("ar_busy", busy, 1'b0);
      check_eq("ar_pc", pc, 9'h000);
      check_eq("ar_ir", ir, 16'h0);
      check_eq("ar_rdata", rdata, 16'h0);
      check_eq("ar_wdata", mem_wdata, 16'h0);
      mem_ready = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      done_seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      check_eq("ar_no_done", done_seen, 0);
      check_eq("ar_idle", busy, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
